// File: rtl/dot_seq.sv
// Streams a vector dot product through an external N-lane MAC array one chunk at a time,
// accumulating each chunk sum into a saturating signed Q.16 result held until out_ready.
module dot_seq #(
  parameter int N        = 49,
  parameter int PIPE_LAT = 8,
  parameter int LEN_W    = 16,
  parameter int ACC_W    = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   vec_len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_a,
  input  logic [15:0]        in_b,
  output logic               arr_en,
  output logic [N*16-1:0]    arr_A_pack,
  output logic [N*16-1:0]    arr_B_pack,
  input  logic [37:0]        arr_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic               out_sat
);
  localparam int LANE_W = $clog2(N + 1);
  localparam int WAIT_W = $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_ACC, S_OUT} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [37:0]       sum_q, sum_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d;
  logic [N*16-1:0]   a_pack_q, a_pack_d, b_pack_q, b_pack_d;

  logic [ACC_W:0]    acc_ext, sum_ext, tot;
  logic              ovf;
  logic [LANE_W-1:0] lane_inc;

  // One guard bit above the accumulator exposes signed overflow of the add.
  always_comb begin
    acc_ext = {acc_q[ACC_W-1], acc_q};
    sum_ext = {{(ACC_W + 1 - 38){sum_q[37]}}, sum_q};
    tot     = acc_ext + sum_ext;
    ovf     = tot[ACC_W] ^ tot[ACC_W-1];
  end

  assign lane_inc = lane_q + LANE_W'(1);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    lane_d   = lane_q;
    wait_d   = wait_q;
    sum_d    = sum_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    a_pack_d = a_pack_q;
    b_pack_d = b_pack_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          sat_d    = 1'b0;
          lane_d   = '0;
          rem_d    = vec_len;
          a_pack_d = '0;
          b_pack_d = '0;
          state_d  = (vec_len == '0) ? S_OUT : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          for (int k = 0; k < N; k++) begin
            if (lane_q == LANE_W'(k)) begin
              a_pack_d[k*16 +: 16] = in_a;
              b_pack_d[k*16 +: 16] = in_b;
            end
          end
          lane_d = lane_inc;
          rem_d  = rem_q - LEN_W'(1);
          if (lane_inc == LANE_W'(N) || rem_q == LEN_W'(1)) begin
            state_d = S_WAIT;
            wait_d  = WAIT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_W'(PIPE_LAT)) begin
          sum_d   = arr_sum;
          wait_d  = '0;
          state_d = S_ACC;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_ACC: begin
        if (ovf) begin
          acc_d = tot[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
          sat_d = 1'b1;
        end else begin
          acc_d = tot[ACC_W-1:0];
        end
        if (rem_q == '0) begin
          state_d = S_OUT;
        end else begin
          state_d  = S_LOAD;
          lane_d   = '0;
          a_pack_d = '0;
          b_pack_d = '0;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      lane_q   <= '0;
      wait_q   <= '0;
      sum_q    <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
      a_pack_q <= '0;
      b_pack_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      lane_q   <= lane_d;
      wait_q   <= wait_d;
      sum_q    <= sum_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      a_pack_q <= a_pack_d;
      b_pack_q <= b_pack_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign in_ready   = (state_q == S_LOAD);
  assign arr_en     = (state_q == S_WAIT);
  assign out_valid  = (state_q == S_OUT);
  assign arr_A_pack = a_pack_q;
  assign arr_B_pack = b_pack_q;
  assign out_data   = acc_q;
  assign out_sat    = sat_q;

endmodule

// File: tb/tb_dot_seq.sv
// Scoreboard bench for dot_seq: a 48-bit and a 40-bit accumulator instance share stimulus,
// each fed by its own behavioural MAC array model.
module tb_dot_seq;
  localparam int N  = 49;
  localparam int PL = 8;
  localparam int LW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, in_valid, out_ready;
  logic [LW-1:0] vec_len;
  logic [15:0]   in_a, in_b;

  logic          busy48, in_ready48, arr_en48, out_valid48, out_sat48;
  logic [N*16-1:0] pa48, pb48;
  logic [37:0]   sum48;
  logic [47:0]   od48;

  logic          busy40, in_ready40, arr_en40, out_valid40, out_sat40;
  logic [N*16-1:0] pa40, pb40;
  logic [37:0]   sum40;
  logic [39:0]   od40;

  dot_seq #(.N(N), .PIPE_LAT(PL), .LEN_W(LW), .ACC_W(48)) dut48 (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .busy(busy48),
    .in_valid(in_valid), .in_ready(in_ready48), .in_a(in_a), .in_b(in_b),
    .arr_en(arr_en48), .arr_A_pack(pa48), .arr_B_pack(pb48), .arr_sum(sum48),
    .out_valid(out_valid48), .out_ready(out_ready), .out_data(od48), .out_sat(out_sat48)
  );

  dot_seq #(.N(N), .PIPE_LAT(PL), .LEN_W(LW), .ACC_W(40)) dut40 (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .busy(busy40),
    .in_valid(in_valid), .in_ready(in_ready40), .in_a(in_a), .in_b(in_b),
    .arr_en(arr_en40), .arr_A_pack(pa40), .arr_B_pack(pb40), .arr_sum(sum40),
    .out_valid(out_valid40), .out_ready(out_ready), .out_data(od40), .out_sat(out_sat40)
  );

  // Array model: Q8.8 x Q8.8 lane products summed; sampled value is PL edges after packs settle.
  function automatic logic [37:0] dotp(input logic [N*16-1:0] pa, input logic [N*16-1:0] pb);
    logic signed [37:0] s;
    logic signed [15:0] x, y;
    logic signed [31:0] p;
    s = '0;
    for (int k = 0; k < N; k++) begin
      x = pa[k*16 +: 16];
      y = pb[k*16 +: 16];
      p = x * y;
      s = s + 38'(p);
    end
    return s;
  endfunction

  logic [37:0] pipe48 [PL-1];
  logic [37:0] pipe40 [PL-1];
  initial begin
    for (int k = 0; k < PL - 1; k++) begin
      pipe48[k] = '0;
      pipe40[k] = '0;
    end
  end
  always @(posedge clk) begin
    pipe48[0] <= dotp(pa48, pb48);
    pipe40[0] <= dotp(pa40, pb40);
    for (int k = 1; k < PL - 1; k++) begin
      pipe48[k] <= pipe48[k-1];
      pipe40[k] <= pipe40[k-1];
    end
  end
  assign sum48 = pipe48[PL-2];
  assign sum40 = pipe40[PL-2];

  typedef struct packed {
    logic [63:0] data;
    logic        sat;
  } exp_t;

  exp_t        q48[$], q40[$];
  logic [15:0] qa[$], qb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per completed result handshake on either instance.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst && out_ready) begin
        if (out_valid48) begin
          if (q48.size() == 0) check("unexpected_out48", 1, 0);
          else begin
            e = q48.pop_front();
            check("data48", 64'($signed(od48)), e.data);
            check("sat48", 64'(out_sat48), 64'(e.sat));
          end
        end
        if (out_valid40) begin
          if (q40.size() == 0) check("unexpected_out40", 1, 0);
          else begin
            e = q40.pop_front();
            check("data40", 64'($signed(od40)), e.data);
            check("sat40", 64'(out_sat40), 64'(e.sat));
          end
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_ctl48"}, {busy48, in_ready48, arr_en48, out_valid48, out_sat48}, 0);
    check({tag, "_data48"}, 64'(od48), 0);
    check({tag, "_pack48"}, 64'(|{pa48, pb48}), 0);
    check({tag, "_ctl40"}, {busy40, in_ready40, arr_en40, out_valid40, out_sat40}, 0);
    check({tag, "_data40"}, 64'(od40), 0);
  endtask

  task automatic fill(input int len, input logic [15:0] a, input logic [15:0] b);
    qa.delete();
    qb.delete();
    for (int k = 0; k < len; k++) begin
      qa.push_back(a);
      qb.push_back(b);
    end
  endtask

  // Caller is at a negedge in LOAD; returns at the negedge after the last transfer.
  task automatic feed(input int len, input bit stall);
    int i = 0;
    int g = 0;
    while (i < len && g < 20000) begin
      in_a     = qa[i];
      in_b     = qb[i];
      in_valid = !(stall && (g % 3 == 1));
      if (in_valid && in_ready48) i++;
      @(negedge clk);
      g++;
    end
    in_valid = 1'b0;
    if (g >= 20000) check("feed_timeout", 64'(i), 64'(len));
  endtask

  task automatic run_vec(input string tag, input int len,
                         input logic [63:0] e48, input logic s48,
                         input logic [63:0] e40, input logic s40,
                         input int exp_lat, input bit stall, input int hold);
    exp_t e;
    int s, c, g;
    logic [47:0] d0;
    e.data = e48; e.sat = s48; q48.push_back(e);
    e.data = e40; e.sat = s40; q40.push_back(e);
    out_ready = (hold == 0);
    start     = 1'b1;
    vec_len   = LW'(len);
    s         = cyc;
    @(negedge clk);
    start = 1'b0;
    if (len == 0) begin
      check({tag, "_outnext"}, 64'(out_valid48), 1);
      check({tag, "_noload"}, {in_ready48, arr_en48, in_ready40, arr_en40}, 0);
    end else begin
      check({tag, "_busy"}, {busy48, busy40, in_ready48}, 3'b111);
    end
    feed(len, stall);
    g = 0;
    while (!out_valid48 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    c = cyc;
    check({tag, "_done"}, {out_valid48, out_valid40}, 2'b11);
    if (exp_lat > 0) check({tag, "_latency"}, 64'(c - s), 64'(exp_lat));
    d0 = od48;
    for (int k = 0; k < hold; k++) begin
      start   = 1'b1;
      vec_len = LW'(5);
      @(negedge clk);
      check({tag, "_hold"}, {out_valid48, od48}, {1'b1, d0});
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle"}, {busy48, out_valid48, busy40, out_valid40}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vec_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    #1 rst = 1'b0;
    #2 check_reset("rst0");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // 49 x (1.0*1.0) = 49.0 -> 0x310000, single chunk
    fill(49, 16'h0100, 16'h0100);
    run_vec("len49", 49, 64'd3211264, 1'b0, 64'd3211264, 1'b0, 59, 1'b0, 0);

    // 50 elements: second chunk carries one element, other lanes must read zero
    fill(50, 16'h0100, 16'h0100);
    run_vec("len50", 50, 64'd3276800, 1'b0, 64'd3276800, 1'b0, 69, 1'b0, 0);

    run_vec("len0", 0, 64'd0, 1'b0, 64'd0, 1'b0, 1, 1'b0, 0);

    // 1*1 + 2*3 + (-1)*4 + 0.5*0.5 = 3.25 with input stalls
    qa.delete(); qb.delete();
    qa.push_back(16'h0100); qb.push_back(16'h0100);
    qa.push_back(16'h0200); qb.push_back(16'h0300);
    qa.push_back(16'hFF00); qb.push_back(16'h0400);
    qa.push_back(16'h0080); qb.push_back(16'h0080);
    run_vec("mixed", 4, 64'd212992, 1'b0, 64'd212992, 1'b0, 0, 1'b1, 0);

    // 3 x (-1.0*1.0) = -3.0
    fill(3, 16'hFF00, 16'h0100);
    run_vec("neg", 3, -64'sd196608, 1'b0, -64'sd196608, 1'b0, 13, 1'b0, 0);

    // 5 x (2.0*2.0) = 20.0, result held with out_ready low for 10 cycles
    fill(5, 16'h0200, 16'h0200);
    run_vec("hold", 5, 64'd1310720, 1'b0, 64'd1310720, 1'b0, 0, 1'b0, 10);

    // 539 x 2^30: fits 48 bits, clamps the 40-bit accumulator to 2^39-1
    fill(539, 16'h8000, 16'h8000);
    run_vec("sat", 539, 64'd539 * 64'd1073741824, 1'b0, 64'd549755813887, 1'b1, 0, 1'b0, 0);

    // Reset pulse in the WAIT of chunk 2, then a fresh run with no residue
    fill(60, 16'h0100, 16'h0100);
    start = 1'b1; vec_len = LW'(60);
    @(negedge clk);
    start = 1'b0;
    feed(60, 1'b0);
    check("wait2_arr_en", {arr_en48, arr_en40}, 2'b11);
    #2 rst = 1'b0;
    #1 check_reset("rst_wait");
    @(negedge clk);
    rst = 1'b1;
    fill(3, 16'h0100, 16'h0200);
    run_vec("after_rst", 3, 64'd393216, 1'b0, 64'd393216, 1'b0, 13, 1'b0, 0);

    repeat (5) @(negedge clk);
    check("q48_drained", 64'(q48.size()), 0);
    check("q40_drained", 64'(q40.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
